// File: rtl/band_demux_if.sv
// Band demux bus: time-multiplexed sample input and frame output.
// master drives din/din_valid/din_sync/frame_ready; slave drives the rest.
interface band_demux_if #(
  parameter int N = 25
);
  logic signed [N-1:0] din;
  logic                din_valid;
  logic                din_sync;
  logic                din_ready;
  logic [1:0]          sel;
  logic signed [N-1:0] hf_o;
  logic signed [N-1:0] mf_o;
  logic signed [N-1:0] lf_o;
  logic                frame_valid;
  logic                frame_ready;
  logic                sync_err;

  modport master (
    output din,
    output din_valid,
    output din_sync,
    output frame_ready,
    input  din_ready,
    input  sel,
    input  hf_o,
    input  mf_o,
    input  lf_o,
    input  frame_valid,
    input  sync_err
  );

  modport slave (
    input  din,
    input  din_valid,
    input  din_sync,
    input  frame_ready,
    output din_ready,
    output sel,
    output hf_o,
    output mf_o,
    output lf_o,
    output frame_valid,
    output sync_err
  );
endinterface

// File: rtl/band_demux.sv
// Splits hf/mf/lf sample stream into a held frame with handshake.
// Ports: clk, reset (async high), bus (band_demux_if.slave).
module band_demux #(
  parameter int N = 25
) (
  input  logic         clk,
  input  logic         reset,
  band_demux_if.slave  bus
);

  typedef enum logic [1:0] {
    S_HF   = 2'b00,
    S_MF   = 2'b01,
    S_LF   = 2'b10,
    S_HOLD = 2'b11
  } state_t;

  state_t              state_q, state_d;
  logic signed [N-1:0] hf_stg_q, hf_stg_d;
  logic signed [N-1:0] mf_stg_q, mf_stg_d;
  logic signed [N-1:0] hf_q, hf_d;
  logic signed [N-1:0] mf_q, mf_d;
  logic signed [N-1:0] lf_q, lf_d;
  logic                fv_q, fv_d;
  logic                err_q, err_d;

  logic rdy;
  logic acc;

  // Only S_HOLD can stall input; it frees the slot
  // exactly when the held frame is consumed.
  assign rdy = (state_q == S_HOLD) ? bus.frame_ready : 1'b1;
  assign acc = bus.din_valid & rdy;

  always_comb begin
    state_d  = state_q;
    hf_stg_d = hf_stg_q;
    mf_stg_d = mf_stg_q;
    hf_d     = hf_q;
    mf_d     = mf_q;
    lf_d     = lf_q;
    fv_d     = fv_q;
    err_d    = 1'b0;
    unique case (state_q)
      S_HF: begin
        if (acc) begin
          if (bus.din_sync) begin
            hf_stg_d = bus.din;
            state_d  = S_MF;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_MF: begin
        if (acc) begin
          if (bus.din_sync) begin
            err_d    = 1'b1;
            hf_stg_d = bus.din;
          end else begin
            mf_stg_d = bus.din;
            state_d  = S_LF;
          end
        end
      end
      S_LF: begin
        if (acc) begin
          if (bus.din_sync) begin
            err_d    = 1'b1;
            hf_stg_d = bus.din;
            state_d  = S_MF;
          end else begin
            hf_d    = hf_stg_q;
            mf_d    = mf_stg_q;
            lf_d    = bus.din;
            fv_d    = 1'b1;
            state_d = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        // A beat accepted here is handled as if already in S_HF,
        // so back-to-back frames run without a bubble.
        if (bus.frame_ready) begin
          fv_d    = 1'b0;
          state_d = S_HF;
          if (acc) begin
            if (bus.din_sync) begin
              hf_stg_d = bus.din;
              state_d  = S_MF;
            end else begin
              err_d = 1'b1;
            end
          end
        end
      end
      default: state_d = S_HF;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_HF;
      hf_stg_q <= '0;
      mf_stg_q <= '0;
      hf_q     <= '0;
      mf_q     <= '0;
      lf_q     <= '0;
      fv_q     <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      hf_stg_q <= hf_stg_d;
      mf_stg_q <= mf_stg_d;
      hf_q     <= hf_d;
      mf_q     <= mf_d;
      lf_q     <= lf_d;
      fv_q     <= fv_d;
      err_q    <= err_d;
    end
  end

  assign bus.din_ready   = rdy;
  assign bus.sel         = state_q;
  assign bus.hf_o        = hf_q;
  assign bus.mf_o        = mf_q;
  assign bus.lf_o        = lf_q;
  assign bus.frame_valid = fv_q;
  assign bus.sync_err    = err_q;

endmodule

// File: tb/tb_band_demux.sv
// Directed bench for band_demux: framing, backpressure, hunt,
// premature sync, async reset and extreme values.
module tb_band_demux;
  localparam int N = 25;

  logic clk;
  logic reset;

  band_demux_if #(.N(N)) bus ();

  band_demux #(.N(N)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_chk;
  int n_fail;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint obs,
                     input longint expv);
    n_chk++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic beat(input logic v, input logic s,
                      input longint d);
    logic signed [63:0] dv;
    dv = d;
    bus.din_valid = v;
    bus.din_sync  = s;
    bus.din       = dv[N-1:0];
    @(posedge clk);
    #1;
    bus.din_valid = 1'b0;
    bus.din_sync  = 1'b0;
  endtask

  task automatic chk_frame(input string tag, input longint h,
                           input longint m, input longint l);
    chk({tag, "_fv"}, longint'(bus.frame_valid), 1);
    chk({tag, "_hf"}, longint'(bus.hf_o), h);
    chk({tag, "_mf"}, longint'(bus.mf_o), m);
    chk({tag, "_lf"}, longint'(bus.lf_o), l);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_sel"}, longint'(bus.sel), 0);
    chk({tag, "_fv"}, longint'(bus.frame_valid), 0);
    chk({tag, "_err"}, longint'(bus.sync_err), 0);
    chk({tag, "_hf"}, longint'(bus.hf_o), 0);
    chk({tag, "_mf"}, longint'(bus.mf_o), 0);
    chk({tag, "_lf"}, longint'(bus.lf_o), 0);
  endtask

  initial begin
    int gap;
    n_chk  = 0;
    n_fail = 0;
    reset           = 1'b1;
    bus.din         = '0;
    bus.din_valid   = 1'b0;
    bus.din_sync    = 1'b0;
    bus.frame_ready = 1'b1;
    #3;
    chk_zero("rst0");
    chk("rst0_rdy", longint'(bus.din_ready), 1);
    @(posedge clk);
    #2;
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Clean frame
    beat(1, 1, 100);
    chk("c1_sel", longint'(bus.sel), 1);
    chk("c1_err", longint'(bus.sync_err), 0);
    beat(1, 0, -200);
    chk("c2_sel", longint'(bus.sel), 2);
    chk("c2_fv", longint'(bus.frame_valid), 0);
    beat(1, 0, 300);
    chk("c3_sel", longint'(bus.sel), 3);
    chk("c3_err", longint'(bus.sync_err), 0);
    chk_frame("c3", 100, -200, 300);
    beat(0, 0, 0);
    chk("c4_sel", longint'(bus.sel), 0);
    chk("c4_fv", longint'(bus.frame_valid), 0);
    chk("c4_hold", longint'(bus.hf_o), 100);

    // Backpressure
    bus.frame_ready = 1'b0;
    beat(1, 1, 40);
    beat(1, 0, 50);
    beat(1, 0, 60);
    chk_frame("bp0", 40, 50, 60);
    for (int i = 0; i < 5; i++) begin
      bus.din_valid = 1'b1;
      bus.din_sync  = 1'b1;
      bus.din       = 25'sd7;
      #1;
      chk("bp_rdy", longint'(bus.din_ready), 0);
      beat(1, 1, 7);
      chk("bp_sel", longint'(bus.sel), 3);
      chk_frame("bp", 40, 50, 60);
    end
    bus.frame_ready = 1'b1;
    bus.din_valid   = 1'b1;
    bus.din_sync    = 1'b1;
    bus.din         = 25'sd7;
    #1;
    chk("bp_rdy1", longint'(bus.din_ready), 1);
    beat(1, 1, 7);
    chk("bp_take_sel", longint'(bus.sel), 1);
    chk("bp_take_fv", longint'(bus.frame_valid), 0);
    chk("bp_take_err", longint'(bus.sync_err), 0);
    beat(1, 0, 8);
    beat(1, 0, 9);
    chk_frame("bp2", 7, 8, 9);
    beat(0, 0, 0);
    chk("bp2_fv0", longint'(bus.frame_valid), 0);

    // Hunt
    beat(1, 0, 5);
    chk("h1_err", longint'(bus.sync_err), 1);
    chk("h1_sel", longint'(bus.sel), 0);
    beat(1, 0, 6);
    chk("h2_err", longint'(bus.sync_err), 1);
    chk("h2_sel", longint'(bus.sel), 0);
    beat(1, 1, 1);
    chk("h3_err", longint'(bus.sync_err), 0);
    chk("h3_sel", longint'(bus.sel), 1);
    beat(1, 0, 2);
    chk("h4_err", longint'(bus.sync_err), 0);
    beat(1, 0, 3);
    chk_frame("h5", 1, 2, 3);
    chk("h5_err", longint'(bus.sync_err), 0);
    beat(0, 0, 0);

    // Premature sync
    beat(1, 1, 10);
    beat(1, 0, 20);
    chk("p2_err", longint'(bus.sync_err), 0);
    beat(1, 1, 11);
    chk("p3_err", longint'(bus.sync_err), 1);
    chk("p3_sel", longint'(bus.sel), 1);
    beat(1, 0, 21);
    chk("p4_err", longint'(bus.sync_err), 0);
    chk("p4_sel", longint'(bus.sel), 2);
    beat(1, 0, 31);
    chk_frame("p5", 11, 21, 31);
    chk("p5_err", longint'(bus.sync_err), 0);
    beat(0, 0, 0);

    // Async reset in S_LF
    beat(1, 1, 70);
    beat(1, 0, 71);
    chk("r1_sel", longint'(bus.sel), 2);
    #2;
    reset = 1'b1;
    #1;
    chk_zero("r1");
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Async reset in S_HOLD
    bus.frame_ready = 1'b0;
    beat(1, 1, 81);
    beat(1, 0, 82);
    beat(1, 0, 83);
    chk_frame("r2pre", 81, 82, 83);
    #2;
    reset = 1'b1;
    #1;
    chk_zero("r2");
    #1;
    reset = 1'b0;
    bus.frame_ready = 1'b1;
    @(posedge clk);
    #1;

    // First edge after reset with no sync hunts
    beat(1, 0, 99);
    chk("r3_err", longint'(bus.sync_err), 1);
    chk("r3_sel", longint'(bus.sel), 0);

    // Extremes with random idle gaps
    gap = int'($urandom_range(0, 3));
    for (int i = 0; i < gap; i++) beat(0, 1, 12345);
    beat(1, 1, -(64'sd1 <<< 24));
    gap = int'($urandom_range(0, 3));
    for (int i = 0; i < gap; i++) begin
      beat(0, 1, 54321);
      chk("x_gap1_sel", longint'(bus.sel), 1);
    end
    beat(1, 0, (64'sd1 <<< 24) - 1);
    gap = int'($urandom_range(0, 3));
    for (int i = 0; i < gap; i++) begin
      beat(0, 1, -1);
      chk("x_gap2_sel", longint'(bus.sel), 2);
    end
    beat(1, 0, 0);
    chk_frame("x", -(64'sd1 <<< 24), (64'sd1 <<< 24) - 1, 0);
    chk("x_err", longint'(bus.sync_err), 0);
    beat(0, 0, 0);
    chk("x_fv0", longint'(bus.frame_valid), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/band_demux.md
BAND_DEMUX -- requirements
Module: band_demux

Interface
REQ-001 SHALL have parameter N, default 25, giving the signed sample width of every band.
REQ-002 SHALL have port clk  in  1  sole clock, all state on rising edge.
REQ-003 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-004 SHALL have port din  in  N  signed time-multiplexed band sample, in the order hf, mf, lf.
REQ-005 SHALL have port din_valid  in  1  din holds a sample.
REQ-006 SHALL have port din_sync  in  1  qualifies din as the hf (first) sample of a frame.
REQ-007 SHALL have port din_ready  out  1  block accepts din this cycle; a beat is accepted when din_valid and din_ready are both 1.
REQ-008 SHALL have port sel  out  2  band expected next: 00 hf, 01 mf, 10 lf, 11 none (frame pending).
REQ-009 SHALL have ports hf_o, mf_o, lf_o  out  N each  signed band values of the last completed frame.
REQ-010 SHALL have port frame_valid  out  1  hf_o/mf_o/lf_o hold an unconsumed frame.
REQ-011 SHALL have port frame_ready  in  1  downstream consumes the frame; the frame is consumed when frame_valid and frame_ready are both 1.
REQ-012 SHALL have port sync_err  out  1  single-cycle pulse on a framing error.

Function
REQ-013 SHALL implement a registered FSM with states S_HF, S_MF, S_LF and S_HOLD; sel is 00, 01, 10 and 11 respectively, decoded from state only.
REQ-014 SHALL drive din_ready as 1 in S_HF, S_MF and S_LF; in S_HOLD din_ready SHALL equal frame_ready (combinational).
REQ-015 S_HF, accepted beat with din_sync=1: capture din into the hf staging register and go to S_MF.
REQ-016 S_HF, accepted beat with din_sync=0: discard the beat, pulse sync_err, and stay in S_HF (hunt).
REQ-017 S_MF, accepted beat with din_sync=0: capture din into the mf staging register and go to S_LF.
REQ-018 S_LF, accepted beat with din_sync=0: in one edge, load hf_o, mf_o and lf_o from hf staging, mf staging and din; set frame_valid; go to S_HOLD.
REQ-019 S_MF or S_LF, accepted beat with din_sync=1 (premature sync): pulse sync_err, discard the partial frame, capture din as the new hf, and go to S_MF.
REQ-020 S_HOLD: frame_valid SHALL stay 1 and hf_o/mf_o/lf_o SHALL stay constant until consumption.
REQ-021 S_HOLD, consumption with no accepted beat: clear frame_valid and go to S_HF.
REQ-022 S_HOLD, consumption with an accepted beat: clear frame_valid and apply the S_HF rules (REQ-015/016) to the beat in the same edge, so back-to-back frames need no bubble.
REQ-023 A beat with din_valid=0 SHALL change no state; idle gaps are allowed between any beats.
REQ-024 hf_o/mf_o/lf_o SHALL change only on the REQ-018 edge; staging registers are never directly visible.
REQ-025 Samples SHALL pass bit-exact: no arithmetic, truncation or sign change.
REQ-026 Latency: frame_valid SHALL rise on the edge that accepts the lf beat, one cycle after that beat is presented.
REQ-027 sync_err SHALL be registered, high for exactly the one cycle after the offending edge.

Reset
REQ-028 While reset=1, regardless of clk, the block SHALL force: state S_HF, sel 00, hf_o/mf_o/lf_o 0, staging registers 0, frame_valid 0, sync_err 0.
REQ-029 Reset SHALL be honoured mid-frame and in S_HOLD; a pending frame is dropped.
REQ-030 The first rising clk edge after reset deasserts SHALL follow the REQ-015/016 rules.

Verification
REQ-031 Clean frame, N=25: beats (sync=1, 100), (0, -200), (0, 300), with frame_ready=1 -> frame_valid=1 for one cycle with hf_o=100, mf_o=-200, lf_o=300; sel sequence 00,01,10,11,00; sync_err never set.
REQ-032 Backpressure: frame_ready=0 for 5 cycles after frame completion -> din_ready=0 and outputs stable for those cycles; the next frame (sync=1, 7), (0, 8), (0, 9) is then presented, with frame_ready raised on the cycle its hf beat is presented -> that beat is accepted on the consuming edge and the next frame_valid shows 7/8/9.
REQ-033 Hunt: beats (sync=0, 5), (sync=0, 6), then (1, 1), (0, 2), (0, 3) -> two sync_err pulses; the single frame output is 1/2/3.
REQ-034 Premature sync: (1, 10), (0, 20), (1, 11), (0, 21), (0, 31) -> one sync_err pulse; the frame output is 11/21/31.
REQ-035 Async reset: assert reset between clock edges in S_LF, then in S_HOLD -> each time all outputs read 0 and sel reads 00 immediately, before the next clk edge.
REQ-036 Extremes: hf=-2^24, mf=2^24-1, lf=0 with random din_valid gaps -> values reproduced bit-exact.
